// File: rtl/alu_driver.sv
// alu_driver: issue-side sequencer for the 16-bit ALU; narrow ops take one pass, wide ops two chained passes.
// Build option: define ALU_DRIVER_ZFLAG_EN to add the rsp_zero response flag.
module alu_driver #(
    parameter int DW = 16,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic          cmd_wide,
    input  logic          cmd_use_carry,
    input  logic [WW-1:0] cmd_a,
    input  logic [WW-1:0] cmd_b,
    output logic          alu_enable,
    output logic [3:0]    alu_sel,
    output logic          alu_c_in,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_c_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [WW-1:0] rsp_data,
    output logic          rsp_carry,
    output logic          rsp_err,
`ifdef ALU_DRIVER_ZFLAG_EN
    output logic          rsp_zero,
`endif
    output logic          carry_flag
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
    state_t        state, state_nxt;
    logic [3:0]    op_q;
    logic          wide_q;
    logic [DW-1:0] a_hi, b_hi;
    logic          legal, carry_op;

    assign legal    = !cmd_wide || cmd_op == 4'd0 || (cmd_op >= 4'd2 && cmd_op <= 4'd7) || cmd_op == 4'd12;
    assign carry_op = op_q[3:1] == 3'd0;

`ifdef ALU_DRIVER_ZFLAG_EN
    assign rsp_zero = rsp_valid && !rsp_err && rsp_data == '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // Next-state plus handshake and ALU-enable decode from the current state
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_enable = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) state_nxt = legal ? LO : RESP;
            end
            LO: begin
                alu_enable = 1'b1;
                state_nxt  = wide_q ? HI : RESP;
            end
            HI: begin
                alu_enable = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, registered ALU drive, result capture and carry bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            wide_q     <= 1'b0;
            a_hi       <= '0;
            b_hi       <= '0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c_in   <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q      <= cmd_op;
                    wide_q    <= cmd_wide;
                    a_hi      <= cmd_a[WW-1:DW];
                    b_hi      <= cmd_b[WW-1:DW];
                    rsp_data  <= '0;
                    rsp_carry <= 1'b0;
                    rsp_err   <= !legal;
                    if (legal) begin
                        alu_sel  <= cmd_op;
                        alu_a    <= cmd_a[DW-1:0];
                        alu_b    <= cmd_b[DW-1:0];
                        alu_c_in <= cmd_use_carry & carry_flag;
                    end
                end
                LO: begin
                    rsp_data[DW-1:0] <= alu_out;
                    if (wide_q) begin
                        alu_a    <= a_hi;
                        alu_b    <= b_hi;
                        alu_c_in <= (op_q == 4'd0) & alu_c_out;
                    end else if (carry_op) begin
                        rsp_carry  <= alu_c_out;
                        carry_flag <= alu_c_out;
                    end
                end
                HI: begin
                    rsp_data[WW-1:DW] <= alu_out;
                    if (carry_op) begin
                        rsp_carry  <= alu_c_out;
                        carry_flag <= alu_c_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed bench for alu_driver with a bench-side ALU and a transaction-level reference model.
module tb_alu_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic        cmd_wide = 1'b0;
    logic        cmd_use_carry = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        alu_enable;
    logic [3:0]  alu_sel;
    logic        alu_c_in;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_c_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;
    logic        carry_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_driver dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
        .cmd_use_carry(cmd_use_carry), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_enable(alu_enable), .alu_sel(alu_sel), .alu_c_in(alu_c_in), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_c_out(alu_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err), .carry_flag(carry_flag)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] w32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~(a | b);
            4'd6: return ~(a ^ b);
            4'd7: return ~(a & b);
            default: return ~a;
        endcase
    endfunction

    // bench ALU: carry-out is junk (1) for non-arithmetic ops and when disabled, so stray sampling shows up
    function automatic logic [16:0] alu16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ci);
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b} + 17'(ci);
            4'd1: return {1'b0, a} - {1'b0, b} - 17'(ci);
            4'd8: return {1'b1, a << 1};
            4'd9: return {1'b1, a >> 1};
            4'd10: return {1'b1, a[14:0], a[15]};
            4'd11: return {1'b1, a[0], a[15:1]};
            4'd13, 4'd14, 4'd15: return {1'b1, a};
            default: return {1'b1, 16'(w32(op, {16'h0, a}, {16'h0, b}))};
        endcase
    endfunction

    function automatic logic [32:0] f_res(input logic [3:0] op, input logic w, input logic ci,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [16:0] n;
        if (w) return (op == 4'd0) ? {1'b0, a} + {1'b0, b} + 33'(ci) : {1'b0, w32(op, a, b)};
        n = alu16(op, a[15:0], b[15:0], ci);
        return {op < 4'd2 && n[16], 16'h0, n[15:0]};
    endfunction

    logic [16:0] alu_r;
    assign alu_r     = alu_enable ? alu16(alu_sel, alu_a, alu_b, alu_c_in) : 17'h1BAD0;
    assign alu_out   = alu_r[15:0];
    assign alu_c_out = alu_r[16];

    // reference model state: one outstanding command
    logic        busy = 1'b0, armed = 1'b0, cf = 1'b0;
    logic [3:0]  m_op = '0;
    logic        m_w = 1'b0, m_uc = 1'b0, m_cf0 = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    int          cyc = 0, acc = 0;

    logic        e_err, lo_cin, hi_cin, cf_after, v_exp, in_lo, in_hi;
    logic [32:0] e_res;
    logic [16:0] lo_sum;
    int          e_lat, ph;
    assign e_err    = m_w && !(m_op == 4'd0 || (m_op >= 4'd2 && m_op <= 4'd7) || m_op == 4'd12);
    assign lo_cin   = m_uc & m_cf0;
    assign e_res    = e_err ? 33'd0 : f_res(m_op, m_w, lo_cin, m_a, m_b);
    assign e_lat    = e_err ? 1 : (m_w ? 3 : 2);
    assign ph       = cyc - acc;
    assign v_exp    = busy && ph >= e_lat;
    assign in_lo    = busy && !e_err && ph == 1;
    assign in_hi    = busy && !e_err && m_w && ph == 2;
    assign lo_sum   = {1'b0, m_a[15:0]} + {1'b0, m_b[15:0]} + 17'(lo_cin);
    assign hi_cin   = m_op == 4'd0 && lo_sum[16];
    assign cf_after = (!e_err && m_op < 4'd2) ? e_res[32] : m_cf0;

    always @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cf    <= 1'b0;
            armed <= 1'b1;
        end else if (v_exp && rsp_ready) begin
            busy <= 1'b0;
            cf   <= cf_after;
        end else if (!busy && cmd_valid) begin
            busy  <= 1'b1;
            acc   <= cyc;
            m_op  <= cmd_op;
            m_w   <= cmd_wide;
            m_uc  <= cmd_use_carry;
            m_a   <= cmd_a;
            m_b   <= cmd_b;
            m_cf0 <= cf;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(rst_n && !busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(v_exp));
            chk("alu_enable", 32'(alu_enable), 32'(in_lo || in_hi));
            chk("carry_flag", 32'(carry_flag), 32'(v_exp ? cf_after : cf));
            if (in_lo || in_hi) begin
                chk("alu_sel", 32'(alu_sel), 32'(m_op));
                chk("alu_a", 32'(alu_a), 32'(in_hi ? m_a[31:16] : m_a[15:0]));
                chk("alu_b", 32'(alu_b), 32'(in_hi ? m_b[31:16] : m_b[15:0]));
                chk("alu_c_in", 32'(alu_c_in), 32'(in_hi ? hi_cin : lo_cin));
            end
            if (v_exp) begin
                chk("rsp_data", rsp_data, e_res[31:0]);
                chk("rsp_carry", 32'(rsp_carry), 32'(e_res[32]));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic w, input logic uc, input logic [31:0] a,
                        input logic [31:0] b, input int hold, output logic [31:0] d, output logic c,
                        output logic e, output int lat, output logic cl, output logic ch);
        int t = 0;
        cmd_op = op; cmd_wide = w; cmd_use_carry = uc; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1; cl = 1'b0; ch = 1'b0;
        while (!rsp_valid && lat < 10) begin
            if (lat == 1) cl = alu_c_in;
            if (lat == 2) ch = alu_c_in;
            @(posedge clk); #1; lat++;
        end
        chk("rsp_arrive", 32'(rsp_valid), 32'd1);
        d = rsp_data; c = rsp_carry; e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, d);
            chk("bp_carry", 32'(rsp_carry), 32'(c));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        c, e, cl, ch;
        int          lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_c_in", 32'(alu_c_in), 32'd0);
        chk("rst_rsp", {rsp_data[28:0], rsp_valid, rsp_carry, rsp_err}, 32'd0);
        chk("rst_carry_flag", 32'(carry_flag), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        send(4'd0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_FFFF, 0, d, c, e, lat, cl, ch);
        chk("nadd_lat", 32'(lat), 32'd2);
        chk("nadd_data", d, 32'h0000_0000);
        chk("nadd_carry", 32'(c), 32'd1);
        chk("nadd_cf", 32'(carry_flag), 32'd1);

        send(4'd0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 0, d, c, e, lat, cl, ch);
        chk("wadd_cin_lo", 32'(cl), 32'd1);
        chk("wadd_cin_hi", 32'(ch), 32'd1);
        chk("wadd_lat", 32'(lat), 32'd3);
        chk("wadd_data", d, 32'h0001_0001);
        chk("wadd_carry", 32'(c), 32'd0);
        chk("wadd_cf", 32'(carry_flag), 32'd0);

        send(4'd0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_FFFF, 0, d, c, e, lat, cl, ch);
        send(4'd8, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 0, d, c, e, lat, cl, ch);
        chk("wshl_lat", 32'(lat), 32'd1);
        chk("wshl_err", 32'(e), 32'd1);
        chk("wshl_data", d, 32'h0000_0000);
        chk("wshl_cf", 32'(carry_flag), 32'd1);

        send(4'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 5, d, c, e, lat, cl, ch);
        chk("xor_lat", 32'(lat), 32'd2);
        chk("xor_data", d, 32'h0000_FF00);
        chk("xor_carry", 32'(c), 32'd0);
        chk("xor_cf", 32'(carry_flag), 32'd1);

        send(4'd1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 0, d, c, e, lat, cl, ch);
        chk("nsub_data", d, 32'h0000_FFFE);
        chk("nsub_carry", 32'(c), 32'd1);

        send(4'd12, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 0, d, c, e, lat, cl, ch);
        chk("wnot_data", d, 32'hEDCB_A987);
        chk("wnot_carry", 32'(c), 32'd0);
        chk("wnot_cf", 32'(carry_flag), 32'd1);

        send(4'd2, 1'b1, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, d, c, e, lat, cl, ch);
        chk("wand_data", d, 32'h0F00_0F00);

        send(4'd3, 1'b0, 1'b0, 32'hAAAA_0F00, 32'h5555_00F0, 0, d, c, e, lat, cl, ch);
        chk("nor_upper_ignored", d, 32'h0000_0FF0);

        send(4'd1, 1'b1, 1'b0, 32'h0000_0009, 32'h0000_0001, 0, d, c, e, lat, cl, ch);
        chk("wsub_err", 32'(e), 32'd1);
        chk("wsub_data", d, 32'h0000_0000);

        send(4'd15, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, d, c, e, lat, cl, ch);
        chk("nop15_err", 32'(e), 32'd0);
        chk("nop15_data", d, 32'h0000_1234);

        send(4'd0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, d, c, e, lat, cl, ch);
        chk("wadd2_data", d, 32'h0000_0000);
        chk("wadd2_carry", 32'(c), 32'd1);
        chk("wadd2_cf", 32'(carry_flag), 32'd1);

        cmd_op = 4'd0; cmd_wide = 1'b1; cmd_use_carry = 1'b0;
        cmd_a = 32'h0001_FFFF; cmd_b = 32'h0000_0001; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hi_enable", 32'(alu_enable), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cf", 32'(carry_flag), 32'd0);
        chk("midrst_enable", 32'(alu_enable), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        send(4'd0, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0003, 0, d, c, e, lat, cl, ch);
        chk("postrst_cin", 32'(cl), 32'd0);
        chk("postrst_data", d, 32'h0000_0005);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
